hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MD_TIMEOUT, default 64, meaning the maximum number of MD_WAIT cycles before abort.
REQ-002 SHALL have parameter CNT_W, default 32, meaning the width of stall_cnt.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-004 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports ID_Rs1 and ID_Rs2, input, 5 bits each: the source registers of the instruction in ID.
REQ-006 SHALL have ports ID_EX_Rd (input, 5 bits) and ID_EX_MemRead (input, 1 bit), describing the instruction in EX.
REQ-007 SHALL have port EX_branch_taken, input, 1 bit: the branch or jump in EX redirects the PC.
REQ-008 SHALL have port EX_md_req, input, 1 bit: the instruction in EX is a multi-cycle mul/div.
REQ-009 SHALL have port md_done, input, 1 bit: the mul/div result is valid this cycle.
REQ-010 SHALL have port md_go, output, 1 bit: a start pulse to the mul/div unit.
REQ-011 SHALL have ports PC_write and IF_ID_write, output, 1 bit each: the register enables.
REQ-012 SHALL have ports IF_ID_flush, ID_EX_flush and EX_MEM_bubble, output, 1 bit each: insert a NOP into the named register.
REQ-013 SHALL have port md_err, output, 1 bit: sticky mul/div timeout flag.
REQ-014 SHALL have port stall_cnt, output, CNT_W bits: the count of cycles with PC_write=0.

Function
REQ-015 SHALL implement the FSM states RUN, MD_WAIT and MD_ABORT.
REQ-016 SHALL drive these defaults in RUN: PC_write=1, IF_ID_write=1, all flush/bubble outputs 0, md_go=0.
REQ-017 SHALL, in RUN with EX_md_req=1: assert md_go for exactly that cycle, freeze the pipeline (PC_write=0, IF_ID_write=0, EX_MEM_bubble=1), and go to MD_WAIT next cycle.
REQ-018 SHALL, in MD_WAIT with md_done=0: keep the freeze (PC_write=0, IF_ID_write=0, EX_MEM_bubble=1), hold md_go=0, and increment the timeout counter.
REQ-019 SHALL, in MD_WAIT with md_done=1: drive the RUN defaults that cycle, so EX_MEM latches the result, return to RUN, and clear the timeout counter.
REQ-020 SHALL, in MD_WAIT when the timeout counter reaches MD_TIMEOUT-1 with md_done=0: set md_err and go to MD_ABORT.
REQ-021 SHALL, in MD_ABORT: for one cycle drive PC_write=1, IF_ID_write=1 and EX_MEM_bubble=0 (the garbage result is committed), then return to RUN.
REQ-022 SHALL ignore md_done in RUN and MD_ABORT.
REQ-023 SHALL, in RUN with EX_md_req=0 and EX_branch_taken=1: drive PC_write=1, IF_ID_flush=1 and ID_EX_flush=1 (two-instruction squash).
REQ-024 SHALL detect a load-use hazard when ID_EX_MemRead=1, ID_EX_Rd!=0, and ID_EX_Rd equals ID_Rs1 or ID_Rs2.
REQ-025 SHALL, in RUN on a load-use hazard with no branch and no md_req: drive PC_write=0, IF_ID_write=0 and ID_EX_flush=1 for one cycle.
REQ-026 SHALL apply the RUN priority: EX_md_req > EX_branch_taken > load-use.
REQ-027 SHALL decode all control outputs combinationally from the state and inputs (Mealy), with no registered latency.
REQ-028 SHALL increment stall_cnt on each clock edge where PC_write=0, saturating at all-ones with no wrap.

Reset
REQ-029 SHALL, while rstn=0, immediately force: state RUN, timeout counter 0, md_err 0, stall_cnt 0.
REQ-030 SHALL keep the outputs at the RUN defaults while in reset.
REQ-031 SHALL treat a reset during MD_WAIT as abandoning the operation, with no md_go re-issue after release.

Structure
REQ-032 SHALL place the state encodings (RUN=2'd0, MD_WAIT=2'd1, MD_ABORT=2'd2) and the NOP control constants in the shared package pipe_ctrl_pkg.
REQ-033 SHALL implement stall_cnt as the sub-module sat_counter (parameter W; ports en, clr, q).

Verification
REQ-034 SHALL cover load-use: ID_EX_MemRead=1, ID_EX_Rd=5, ID_Rs2=5 -> exactly one cycle of PC_write=0, IF_ID_write=0, ID_EX_flush=1, and stall_cnt goes 0->1.
REQ-035 SHALL cover the x0 case: ID_EX_MemRead=1, ID_EX_Rd=0, ID_Rs1=0 -> no stall.
REQ-036 SHALL cover branch versus load-use: EX_branch_taken=1 with a load-use match -> PC_write=1, IF_ID_flush=1, ID_EX_flush=1.
REQ-037 SHALL cover mul/div: EX_md_req=1, md_done arriving 5 cycles after md_go -> md_go high exactly 1 cycle, freeze for 5 cycles, release on the md_done cycle, stall_cnt=5.
REQ-038 SHALL cover timeout: MD_TIMEOUT=8, md_done never asserted -> md_err=1 after 8 MD_WAIT cycles, one MD_ABORT cycle, then RUN, with md_err held until reset.
REQ-039 SHALL cover saturation and reset: CNT_W=4 with 20 stall cycles -> stall_cnt=15; rstn pulsed low mid-MD_WAIT -> stall_cnt=0, state RUN, and md_go stays 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: hazard FSM state encodings and the
// per-cycle control words (PC/IF_ID enables, flush/bubble requests, md_go).
package pipe_ctrl_pkg;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MD_WAIT  = 2'd1;
  localparam logic [1:0] ST_MD_ABORT = 2'd2;

  // Canonical RV32 NOP (addi x0, x0, 0) that flush/bubble logic injects.
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_bubble;
    logic md_go;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                 id_ex_flush: 1'b0, ex_mem_bubble: 1'b0, md_go: 1'b0};
  localparam ctrl_t CTRL_BRANCH = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                                    id_ex_flush: 1'b1, ex_mem_bubble: 1'b0, md_go: 1'b0};
  localparam ctrl_t CTRL_LOAD_USE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                      id_ex_flush: 1'b1, ex_mem_bubble: 1'b0, md_go: 1'b0};
  localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                    id_ex_flush: 1'b0, ex_mem_bubble: 1'b1, md_go: 1'b0};
  localparam ctrl_t CTRL_MD_START = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                      id_ex_flush: 1'b0, ex_mem_bubble: 1'b1, md_go: 1'b1};

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous clear.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch squash and
// multi-cycle mul/div freeze with timeout abort, plus a stall-cycle counter.
import pipe_ctrl_pkg::*;

module hazard_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [4:0]       ID_Rs1,
  input  logic [4:0]       ID_Rs2,
  input  logic [4:0]       ID_EX_Rd,
  input  logic             ID_EX_MemRead,
  input  logic             EX_branch_taken,
  input  logic             EX_md_req,
  input  logic             md_done,
  output logic             md_go,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             EX_MEM_bubble,
  output logic             md_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int TW = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(MD_TIMEOUT - 1);

  logic [1:0]    r_state;
  logic [1:0]    w_state_next;
  logic [TW-1:0] r_to_cnt;
  logic          r_md_err;
  logic          w_load_use;
  logic          w_waiting;
  logic          w_timeout;
  ctrl_t         w_ctrl;

  assign w_load_use = ID_EX_MemRead && (ID_EX_Rd != 5'd0) &&
                      ((ID_EX_Rd == ID_Rs1) || (ID_EX_Rd == ID_Rs2));
  assign w_waiting  = (r_state == ST_MD_WAIT) && !md_done;
  assign w_timeout  = w_waiting && (r_to_cnt == TO_LAST);

  always_comb begin
    w_ctrl       = CTRL_RUN;
    w_state_next = r_state;
    case (r_state)
      ST_RUN: begin
        if (EX_md_req) begin
          w_ctrl       = CTRL_MD_START;
          w_state_next = ST_MD_WAIT;
        end else if (EX_branch_taken) begin
          w_ctrl = CTRL_BRANCH;
        end else if (w_load_use) begin
          w_ctrl = CTRL_LOAD_USE;
        end
      end
      ST_MD_WAIT: begin
        if (md_done) begin
          w_state_next = ST_RUN;
        end else begin
          w_ctrl = CTRL_FREEZE;
          if (w_timeout) begin
            w_state_next = ST_MD_ABORT;
          end
        end
      end
      // The abort cycle releases the freeze so the unfinished result commits.
      ST_MD_ABORT: w_state_next = ST_RUN;
      default:     w_state_next = ST_RUN;
    endcase
    if (!rstn) begin
      w_ctrl = CTRL_RUN;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ST_RUN;
      r_to_cnt <= '0;
      r_md_err <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_to_cnt <= (w_waiting && !w_timeout) ? r_to_cnt + 1'b1 : '0;
      if (w_timeout) begin
        r_md_err <= 1'b1;
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rstn(rstn),
    .en  (!w_ctrl.pc_write),
    .clr (1'b0),
    .q   (stall_cnt)
  );

  assign md_go         = w_ctrl.md_go;
  assign PC_write      = w_ctrl.pc_write;
  assign IF_ID_write   = w_ctrl.if_id_write;
  assign IF_ID_flush   = w_ctrl.if_id_flush;
  assign ID_EX_flush   = w_ctrl.id_ex_flush;
  assign EX_MEM_bubble = w_ctrl.ex_mem_bubble;
  assign md_err        = r_md_err;

endmodule
